// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock via trial subtraction.
// Optional signed mode (is_signed port, FIXUP state) when SEQ_DIV_SIGNED_EN is defined.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // RUN   | one restoring step per cycle, count down from WIDTH
  // FIXUP | apply signs to magnitude results (signed build only)
  // FIN   | publish results, pulse done, return to IDLE
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, FIN} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvsr;
  logic             dz;
`ifdef SEQ_DIV_SIGNED_EN
  logic             sgn_op;
  logic             neg_q;
  logic             neg_r;
`endif

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dvs_in;

  always_comb begin
    rem_shift = {rem_r, dq[WIDTH-1]};
    trial     = {1'b0, rem_shift} + {2'b01, ~dvsr} + (WIDTH + 2)'(1);
    // bit WIDTH of the sum is always the inverse of the carry-out
    no_borrow = trial[WIDTH+1] & ~trial[WIDTH];
    rem_next  = no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
`ifdef SEQ_DIV_SIGNED_EN
    dvd_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_in = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
`else
    dvd_in = dividend;
    dvs_in = divisor;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      rem_r       <= '0;
      dq          <= '0;
      dvsr        <= '0;
      dz          <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_op      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              dz    <= 1'b1;
              dq    <= '1;
              rem_r <= dividend;
              state <= FIN;
            end else begin
              dz    <= 1'b0;
              dq    <= dvd_in;
              dvsr  <= dvs_in;
              rem_r <= '0;
              count <= CW'(WIDTH);
              state <= RUN;
            end
`ifdef SEQ_DIV_SIGNED_EN
            sgn_op <= is_signed;
            neg_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r  <= is_signed & dividend[WIDTH-1];
`endif
          end
        end
        RUN: begin
          rem_r <= rem_next;
          dq    <= {dq[WIDTH-2:0], no_borrow};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
`ifdef SEQ_DIV_SIGNED_EN
            state <= sgn_op ? FIXUP : FIN;
`else
            state <= FIN;
`endif
          end
        end
`ifdef SEQ_DIV_SIGNED_EN
        FIXUP: begin
          if (neg_q) dq <= -dq;
          if (neg_r) rem_r <= -rem_r;
          state <= FIN;
        end
`endif
        FIN: begin
          quotient    <= dq;
          remainder   <= rem_r;
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against an arithmetic reference model.
module tb_seq_restoring_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, is_signed;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;
  int           n_checks = 0;
  int           n_fail = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    int sa, sb;
    dz = 1'b0;
    lat = s ? W + 2 : W + 1;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 0;
      end else begin
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
      end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge with inputs scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h expected all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_basic;
    int cyc; bit ok;
    launch(100, 7, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != W + 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d (seen=%0d) expected %0d", cyc, ok, W + 1);
    end
    n_checks++;
    if (quotient !== 14 || remainder !== 2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b busy=%b expected 14 2 0 0",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got done=%b expected 0", done); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (quotient !== 14 || remainder !== 2) begin
      n_fail++; $display("FAIL basic_hold: got q=%0d r=%0d expected 14 2", quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    int cyc; bit ok;
    launch(5, 0, 1'b0);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 5 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result: got q=%h r=%0d dz=%b expected ffffffff 5 1",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit ok;
    launch(32'hFFFF_FFFF, 1, 1'b0);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || quotient !== 32'hFFFF_FFFF || remainder !== 0) begin
      n_fail++; $display("FAIL b2b_first: got q=%h r=%h expected ffffffff 0", quotient, remainder);
    end
    launch(3, 32'hFFFF_FFFF, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != W + 1 || quotient !== 0 || remainder !== 3 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc=%0d q=%h r=%h dz=%b expected %0d 0 3 0",
               cyc, quotient, remainder, div_by_zero, W + 1);
    end
  endtask

  task automatic test_start_ignored;
    int cyc, pulses; bit ok;
    launch(100, 7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dividend = 9; divisor = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc + 10 != W + 1 || quotient !== 14 || remainder !== 2) begin
      n_fail++;
      $display("FAIL ignore_result: got total=%0d q=%0d r=%0d expected %0d 14 2",
               cyc + 10, quotient, remainder, W + 1);
    end
    pulses = 0;
    repeat (45) begin @(posedge clk); #1; if (done) pulses++; end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL ignore_extra_done: got %0d expected 0", pulses); end
  endtask

  task automatic test_abort;
    int cyc, pulses; bit ok;
    launch(100, 7, 1'b0);
    repeat (14) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_checks++;
    if ({busy, done, quotient, remainder} !== '0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b done=%b q=%h r=%h expected zero",
               busy, done, quotient, remainder);
    end
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) pulses++; end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", pulses); end
    launch(50, 5, 1'b0);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || quotient !== 10 || remainder !== 0) begin
      n_fail++; $display("FAIL abort_after: got q=%0d r=%0d expected 10 0", quotient, remainder);
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed;
    int cyc; bit ok;
    launch(-32'sd7, 2, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != W + 2 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL signed_neg7_2: got cyc=%0d q=%h r=%h expected %0d fffffffd ffffffff",
               cyc, quotient, remainder, W + 2);
    end
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || quotient !== 32'h8000_0000 || remainder !== 0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_overflow: got q=%h r=%h dz=%b expected 80000000 0 0",
               quotient, remainder, div_by_zero);
    end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic s, edz;
    int lat, cyc; bit ok;
    for (int i = 0; i < 40; i++) begin
      a = (i % 3 == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      case (i % 4)
        0: b = W'($urandom_range(1, 15));
        1: b = W'($urandom);
        2: b = (i % 8 == 2) ? '0 : W'($urandom_range(1, 70000));
        default: b = a + W'($urandom_range(0, 2));
      endcase
`ifdef SEQ_DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      model(a, b, s, eq, er, edz, lat);
      launch(a, b, s);
      wait_done(cyc, ok);
      n_checks++;
      if (!ok || cyc != lat || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
        n_fail++;
        $display("FAIL random_%0d: %h/%h s=%b got cyc=%0d q=%h r=%h dz=%b expected %0d %h %h %b",
                 i, a, b, s, cyc, quotient, remainder, div_by_zero, lat, eq, er, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_start_ignored();
    test_abort();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
